// File: rtl/rom_arbiter.sv
// Arbiter sharing the instruction/data memory between boot loader, LSU and IFU.
// Owns the BOOT/RUN sequencing, LSU-over-IFU priority with IFU anti-starvation and one-cycle responses.
module rom_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter bit          BOOT_BYPASS  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ldr_req_i,
  input  logic [31:0] ldr_addr_i,
  input  logic [31:0] ldr_data_i,
  input  logic        boot_done_i,
  output logic        ldr_gnt_o,
  output logic        ldr_ack_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_sel_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rsp_valid_o,
  output logic [31:0] lsu_rdata_o,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_gnt_o,
  output logic        ifu_rsp_valid_o,
  output logic [31:0] ifu_rdata_o,
  output logic        running_o,
  output logic [31:0] mem_r_addr_o,
  input  logic [31:0] mem_r_data_i,
  output logic        mem_w_en_o,
  output logic [31:0] mem_w_addr_o,
  output logic [31:0] mem_w_data_o,
  output logic [3:0]  mem_w_sel_o
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e     RESET_STATE = BOOT_BYPASS ? ST_RUN : ST_BOOT;
  localparam logic [7:0] LIMIT       = 8'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        running_q, running_d;
  logic        ldr_ack_q, ldr_ack_d;
  logic        lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic        ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;

  logic        ldr_gnt_s, lsu_gnt_s, ifu_gnt_s, ifu_wins_s;

  // Grant decode; grants are held low for the whole time reset is asserted.
  always_comb begin
    ldr_gnt_s  = 1'b0;
    lsu_gnt_s  = 1'b0;
    ifu_gnt_s  = 1'b0;
    ifu_wins_s = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_BOOT: begin
          ldr_gnt_s = ldr_req_i;
        end
        ST_RUN: begin
          ifu_wins_s = ifu_req_i && (starve_cnt_q == LIMIT);
          lsu_gnt_s  = lsu_req_i && !ifu_wins_s;
          ifu_gnt_s  = ifu_req_i && !lsu_gnt_s;
        end
        default: begin
          ldr_gnt_s = 1'b0;
        end
      endcase
    end else begin
      ldr_gnt_s = 1'b0;
    end
  end

  // Memory port mux: only the granted requester reaches the memory, idle drives zero.
  always_comb begin
    mem_r_addr_o = 32'h0000_0000;
    mem_w_en_o   = 1'b0;
    mem_w_addr_o = 32'h0000_0000;
    mem_w_data_o = 32'h0000_0000;
    mem_w_sel_o  = 4'b0000;
    if (ldr_gnt_s) begin
      mem_w_en_o   = 1'b1;
      mem_w_addr_o = ldr_addr_i;
      mem_w_data_o = ldr_data_i;
      mem_w_sel_o  = 4'b1111;
    end else if (lsu_gnt_s && lsu_we_i) begin
      mem_w_en_o   = 1'b1;
      mem_w_addr_o = lsu_addr_i;
      mem_w_data_o = lsu_wdata_i;
      mem_w_sel_o  = lsu_sel_i;
    end else if (lsu_gnt_s) begin
      mem_r_addr_o = lsu_addr_i;
    end else if (ifu_gnt_s) begin
      mem_r_addr_o = ifu_addr_i;
    end else begin
      mem_r_addr_o = 32'h0000_0000;
    end
  end

  // Next state, starvation counter and response capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_done_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    starve_cnt_d = starve_cnt_q;
    if ((state_q != ST_RUN) || !ifu_req_i || ifu_gnt_s) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_d = LIMIT;
    end

    running_d       = (state_d == ST_RUN);
    ldr_ack_d       = ldr_gnt_s;
    lsu_rsp_valid_d = lsu_gnt_s;
    ifu_rsp_valid_d = ifu_gnt_s;

    lsu_rdata_d = lsu_rdata_q;
    if (lsu_gnt_s && !lsu_we_i) begin
      lsu_rdata_d = mem_r_data_i;
    end else begin
      lsu_rdata_d = lsu_rdata_q;
    end

    ifu_rdata_d = ifu_rdata_q;
    if (ifu_gnt_s) begin
      ifu_rdata_d = mem_r_data_i;
    end else begin
      ifu_rdata_d = ifu_rdata_q;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RESET_STATE;
      starve_cnt_q    <= 8'd0;
      running_q       <= BOOT_BYPASS;
      ldr_ack_q       <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rdata_q     <= 32'h0000_0000;
      ifu_rdata_q     <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      starve_cnt_q    <= starve_cnt_d;
      running_q       <= running_d;
      ldr_ack_q       <= ldr_ack_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      lsu_rdata_q     <= lsu_rdata_d;
      ifu_rdata_q     <= ifu_rdata_d;
    end
  end

  assign ldr_gnt_o       = ldr_gnt_s;
  assign lsu_gnt_o       = lsu_gnt_s;
  assign ifu_gnt_o       = ifu_gnt_s;
  assign ldr_ack_o       = ldr_ack_q;
  assign lsu_rsp_valid_o = lsu_rsp_valid_q;
  assign ifu_rsp_valid_o = ifu_rsp_valid_q;
  assign lsu_rdata_o     = lsu_rdata_q;
  assign ifu_rdata_o     = ifu_rdata_q;
  assign running_o       = running_q;

endmodule
